// File: rtl/tp84_lpf_sched_if.sv
// Bundle of channel samples, filter selects and filtered results for the TP84 LPF scheduler.
// Latency: none (wires only). Each direction is a plain bus with no handshake.
// Backpressure: none; out_vld is a one-cycle pulse and the consumer must take it then.
//
// Ports:
//   in_dat   16*NCH  signed channel inputs, channel c at [16c+15:16c]
//   sel_dat  2*NCH   per-channel select: 00 bypass, 01 light, 10 medium, 11 heavy
//   out_dat  16*NCH  signed filtered outputs, same packing as in_dat
//   out_vld  1       pulses for one cycle when out_dat updates
//   busy     1       high while the scheduler is working through the channels
interface tp84_lpf_sched_if #(
  parameter int NCH = 4
);
  logic [16*NCH-1:0] in_dat;
  logic [2*NCH-1:0]  sel_dat;
  logic [16*NCH-1:0] out_dat;
  logic              out_vld;
  logic              busy;

  modport master (
    output in_dat,
    output sel_dat,
    input  out_dat,
    input  out_vld,
    input  busy
  );

  modport slave (
    input  in_dat,
    input  sel_dat,
    output out_dat,
    output out_vld,
    output busy
  );
endinterface

// File: rtl/tp84_lpf_sched.sv
// Time-multiplexed first-order IIR low-pass bank: one 18x18 multiplier and one accumulator serve NCH channels.
// Latency: out_vld is visible 4*NCH+1 edges after the capture edge (cnt==0) and repeats every DIV cycles.
// Backpressure: none; the inputs are sampled at capture and out_dat is held between out_vld pulses.
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     slave side of tp84_lpf_sched_if (in_dat, sel_dat in; out_dat, out_vld, busy out)
module tp84_lpf_sched #(
  parameter int NCH = 4,
  parameter int DIV = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tp84_lpf_sched_if.slave bus
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] CH_LAST = IW'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_STORE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      ch_q, ch_d;
  logic signed [35:0] acc_q, acc_d;

  // Sample registers loaded at capture, plus the per-channel filter memory.
  logic signed [15:0] xs_q  [NCH];
  logic signed [15:0] xs_d  [NCH];
  logic [1:0]         ss_q  [NCH];
  logic [1:0]         ss_d  [NCH];
  logic signed [15:0] x1_q  [NCH];
  logic signed [15:0] x1_d  [NCH];
  logic signed [15:0] y1_q  [NCH];
  logic signed [15:0] y1_d  [NCH];
  logic signed [15:0] res_q [NCH];
  logic signed [15:0] res_d [NCH];

  logic [16*NCH-1:0]  out_q, out_d;
  logic               out_vld_q, out_vld_d;

  logic               capture;
  logic signed [15:0] cur_x, cur_x1, cur_y1;
  logic [1:0]         cur_sel;
  logic signed [17:0] mul_a, mul_b;
  logic signed [35:0] prod;
  logic signed [35:0] acc_shr;
  logic signed [15:0] sat_y;

  // Feed-forward coefficient B (B1 == B2) in Q15.
  function automatic logic signed [17:0] coef_b(input logic [1:0] s);
    logic signed [17:0] r;
    case (s)
      2'b01:   r = 18'sd1488;
      2'b10:   r = 18'sd600;
      2'b11:   r = 18'sd250;
      default: r = 18'sd0;
    endcase
    return r;
  endfunction

  // Feedback coefficient stored already negated (-A2), so every MAC step is an add.
  function automatic logic signed [17:0] coef_na2(input logic [1:0] s);
    logic signed [17:0] r;
    case (s)
      2'b01:   r = 18'sd29791;
      2'b10:   r = 18'sd31568;
      2'b11:   r = 18'sd32268;
      default: r = 18'sd0;
    endcase
    return r;
  endfunction

  // Free-running sample-rate divider.
  assign cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  // A capture arriving mid-sequence (DIV too small) is dropped rather than corrupting the pass.
  assign capture = (cnt_q == '0) && (state_q == S_IDLE);

  assign cur_x   = xs_q[ch_q];
  assign cur_x1  = x1_q[ch_q];
  assign cur_y1  = y1_q[ch_q];
  assign cur_sel = ss_q[ch_q];

  // Shared multiplier operand steering.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MAC0: begin
        mul_a = coef_b(cur_sel);
        mul_b = 18'(cur_x);
      end
      S_MAC1: begin
        mul_a = coef_b(cur_sel);
        mul_b = 18'(cur_x1);
      end
      S_MAC2: begin
        mul_a = coef_na2(cur_sel);
        mul_b = 18'(cur_y1);
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign prod    = 36'(mul_a) * 36'(mul_b);
  // Arithmetic shift floors toward minus infinity.
  assign acc_shr = acc_q >>> 15;

  always_comb begin
    sat_y = acc_shr[15:0];
    if (acc_shr > 36'sd32767) begin
      sat_y = 16'sh7fff;
    end else if (acc_shr < -36'sd32768) begin
      sat_y = 16'sh8000;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    xs_d      = xs_q;
    ss_d      = ss_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    res_d     = res_q;
    out_d     = out_q;
    out_vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          for (int c = 0; c < NCH; c++) begin
            xs_d[c] = bus.in_dat[16*c +: 16];
            ss_d[c] = bus.sel_dat[2*c +: 2];
          end
          ch_d    = '0;
          state_d = S_MAC0;
        end
      end
      S_MAC0: begin
        acc_d   = prod;
        state_d = S_MAC1;
      end
      S_MAC1: begin
        acc_d   = acc_q + prod;
        state_d = S_MAC2;
      end
      S_MAC2: begin
        acc_d   = acc_q + prod;
        state_d = S_STORE;
      end
      S_STORE: begin
        // Bypass preloads both history taps with x so a later switch into a
        // filter mode starts from steady state instead of stepping from zero.
        if (cur_sel == 2'b00) begin
          res_d[ch_q] = cur_x;
          y1_d[ch_q]  = cur_x;
        end else begin
          res_d[ch_q] = sat_y;
          y1_d[ch_q]  = sat_y;
        end
        x1_d[ch_q] = cur_x;
        if (ch_q == CH_LAST) begin
          ch_d    = '0;
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_MAC0;
        end
      end
      S_DONE: begin
        // All channels publish together so out_dat never shows a half-updated set.
        for (int c = 0; c < NCH; c++) begin
          out_d[16*c +: 16] = res_q[c];
        end
        out_vld_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        xs_q[c]  <= '0;
        ss_q[c]  <= '0;
        x1_q[c]  <= '0;
        y1_q[c]  <= '0;
        res_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      xs_q      <= xs_d;
      ss_q      <= ss_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      res_q     <= res_d;
    end
  end

  assign bus.out_dat = out_q;
  assign bus.out_vld = out_vld_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_tp84_lpf_sched.sv
// Directed bench for tp84_lpf_sched: reset state, latency/period, per-mode values and filter history.
// Latency: expects out_vld 18 edges after reset release, then every 256 cycles.
// Backpressure: none; the bench samples every out_vld pulse as it occurs.
module tb_tp84_lpf_sched;

  localparam int NCH = 4;
  localparam int DIV = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tp84_lpf_sched_if #(.NCH(NCH)) bus ();

  tp84_lpf_sched #(.NCH(NCH), .DIV(DIV)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference history per channel and the expected result of the pending sample.
  int m_x1  [NCH];
  int m_y1  [NCH];
  int exp_y [NCH];
  int hist  [64][NCH];
  logic [2*NCH-1:0] cur_sel;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // y = floor((B*x + B*x1 + (-A2)*y1) / 2^15), saturated; bypass passes x through.
  function automatic int model(input logic [1:0] s, input int x, input int x1, input int y1);
    longint b, na, acc;
    case (s)
      2'b01:   begin b = 1488; na = 29791; end
      2'b10:   begin b = 600;  na = 31568; end
      2'b11:   begin b = 250;  na = 32268; end
      default: begin b = 0;    na = 0;     end
    endcase
    if (s == 2'b00) return x;
    acc = (b * x + b * x1 + na * y1) >>> 15;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  // Stimulus tables. Set 0: channel independence; set 1: light step and bypass.
  task automatic stim(input int which, input int k, input int c, output int x, output logic [1:0] s);
    if (which == 0) begin
      s = 2'(c);
      x = (c == 2 && k >= 3) ? -20000 : 8000;
    end else begin
      case (c)
        0:       begin s = 2'b01; x = 10000; end
        1:       begin s = (k == 0) ? 2'b00 : 2'b01; x = -12345; end
        2:       begin s = 2'b11; x = -32768; end
        default: begin s = 2'b10; x = 32767; end
      endcase
    end
  endtask

  task automatic apply_next(input int which, input int k);
    int x;
    logic [1:0] s;
    for (int c = 0; c < NCH; c++) begin
      stim(which, k, c, x, s);
      bus.in_dat[16*c +: 16] = 16'(x);
      cur_sel[2*c +: 2] = s;
      exp_y[c] = model(s, x, m_x1[c], m_y1[c]);
      m_x1[c] = x;
      m_y1[c] = exp_y[c];
    end
    bus.sel_dat = cur_sel;
  endtask

  // Releases reset and checks nsamp consecutive output samples against the model.
  // With tog set, sel is scrambled while the DUT is busy to show it is only read at capture.
  task automatic run_seq(input int which, input int nsamp, input bit tog, input string tag);
    int cyc;
    int v;
    logic signed [15:0] v16;
    for (int c = 0; c < NCH; c++) begin
      m_x1[c] = 0;
      m_y1[c] = 0;
    end
    apply_next(which, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < nsamp; k++) begin
      cyc = 0;
      for (int i = 1; i <= 400; i++) begin
        @(posedge clk);
        #1;
        if (tog && bus.busy) bus.sel_dat = ~cur_sel;
        if (bus.out_vld) begin
          cyc = i;
          break;
        end
      end
      chk($sformatf("%s_s%0d_%s", tag, k, (k == 0) ? "latency" : "period"), cyc, (k == 0) ? 18 : DIV);
      if (cyc == 0) break;
      for (int c = 0; c < NCH; c++) begin
        v16 = bus.out_dat[16*c +: 16];
        v = int'(v16);
        hist[k][c] = v;
        chk($sformatf("%s_s%0d_ch%0d", tag, k, c), v, exp_y[c]);
      end
      if (k + 1 < nsamp) apply_next(which, k + 1);
    end
  endtask

  task automatic check_indep(input string tag);
    chk({tag, "_bypass_8000"}, hist[0][0], 8000);
    chk({tag, "_light_363"},   hist[0][1], 363);
    chk({tag, "_medium_146"},  hist[0][2], 146);
    chk({tag, "_heavy_61"},    hist[0][3], 61);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int vld_seen;
    int viol;
    int maxv;

    bus.in_dat  = {$urandom, $urandom};
    bus.sel_dat = 8'($urandom);
    cur_sel     = '0;
    rst_n       = 1'b0;

    // Reset state with arbitrary inputs applied.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_lo", int'(bus.out_dat[31:0]), 0);
    chk("rst_out_hi", int'(bus.out_dat[63:32]), 0);
    chk("rst_vld",    int'(bus.out_vld), 0);
    chk("rst_busy",   int'(bus.busy), 0);

    // Four modes side by side, in2 changes alone from sample 3, sel scrambled mid-sample.
    run_seq(0, 6, 1'b1, "indep");
    check_indep("indep");

    // Abort mid-sequence: reset lands in cycle T0+7 of the next pass.
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) begin
        found = 1;
        break;
      end
    end
    chk("midrst_busy_rise", found, 1);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   int'(bus.busy), 0);
    chk("midrst_vld",    int'(bus.out_vld), 0);
    chk("midrst_out_lo", int'(bus.out_dat[31:0]), 0);
    chk("midrst_out_hi", int'(bus.out_dat[63:32]), 0);
    vld_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_vld) vld_seen++;
    end
    chk("midrst_no_vld", vld_seen, 0);

    // Post-release sequence must match the power-up one.
    run_seq(0, 6, 1'b1, "rerun");
    check_indep("rerun");

    // Light step, bypass hand-over, and heavy/medium at full-scale inputs.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    run_seq(1, 60, 1'b0, "step");
    chk("step_first_454",   hist[0][0], 454);
    chk("step_second_1320", hist[1][0], 1320);
    chk("bypass_first",     hist[0][1], -12345);
    chk("bypass_to_light",  hist[1][1], -12345);
    viol = 0;
    maxv = hist[0][0];
    for (int k = 1; k < 60; k++) begin
      if (hist[k][0] < hist[k-1][0]) viol++;
      if (hist[k][0] > maxv) maxv = hist[k][0];
    end
    chk("step_monotonic", viol, 0);
    chk("step_le_10000",  int'(maxv <= 10000), 1);
    chk("step_near_9996", int'(hist[59][0] >= 9900), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
